// File: rtl/seg_pkg.sv
// seg_pkg: shared register offsets, mode encoding and display constants for seven-segment blocks.
package seg_pkg;
    typedef enum logic {MODE_RAW = 1'b0, MODE_SCAN = 1'b1} mode_t;
    localparam logic [31:0] OFF_RAW = 32'd0;
    localparam logic [31:0] OFF_HEX = 32'd4;
    localparam logic [31:0] OFF_CTRL = 32'd8;
    localparam logic [11:0] LEDS_RESET = 12'hf80;
    localparam logic [11:0] LEDS_BLANK = 12'hf00;
endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: MemRead/MemWrite data bus as seen by a memory-mapped peripheral.
interface seg_display_ctrl_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        hit;
    modport master (output MemRead, MemWrite, Address, Write_data, input Read_data, hit);
    modport slave (input MemRead, MemWrite, Address, Write_data, output Read_data, hit);
endinterface

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-high segments g..a (bit 0 = a).
module hex_to_seg (
    input  logic [3:0] d,
    output logic [6:0] seg
);
    // Entry n sits at bits [7n+6:7n]; listed from F down to 0.
    localparam logic [111:0] TBL = {7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
                                    7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f};
    assign seg = TBL[d * 7 +: 7];
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped seven-segment peripheral with RAW word and hardware-scanned HEX modes.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int          SCAN_DIV  = 100000
) (
    input  logic                clk,
    input  logic                reset,
    seg_display_ctrl_if.slave   bus,
    output logic [11:0]         leds
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [11:0]   raw;
    logic [15:0]   hex;
    logic [3:0]    dp;
    mode_t         mode;
    logic          blank;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          frame_done;
    logic          sel_raw, sel_hex, sel_ctrl, wr, wrap;
    logic [6:0]    seg;
    logic [11:0]   leds_nxt;
    logic          unused;

    assign sel_raw  = bus.Address == BASE_ADDR + OFF_RAW;
    assign sel_hex  = bus.Address == BASE_ADDR + OFF_HEX;
    assign sel_ctrl = bus.Address == BASE_ADDR + OFF_CTRL;
    assign bus.hit  = sel_raw | sel_hex | sel_ctrl;
    assign wr       = bus.MemWrite & bus.hit;
    assign wrap     = cnt == CW'(SCAN_DIV - 1);
    assign unused   = &{1'b0, bus.Write_data[31:20]};

    assign bus.Read_data = !bus.MemRead ? '0 :
                           sel_raw  ? {20'b0, raw} :
                           sel_hex  ? {12'b0, dp, hex} :
                           sel_ctrl ? {27'b0, blank, frame_done, idx, mode} : '0;

    hex_to_seg u_dec (.d(hex[idx * 4 +: 4]), .seg(seg));

    always_comb begin
        leds_nxt = blank ? LEDS_BLANK :
                   mode == MODE_RAW ? raw : {~(4'b0001 << idx), dp[idx], seg};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw        <= LEDS_RESET;
            hex        <= '0;
            dp         <= '0;
            mode       <= MODE_RAW;
            blank      <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
            leds       <= LEDS_RESET;
        end else begin
            if (mode == MODE_SCAN) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                if (wrap) idx <= idx + 2'd1;
            end
            if (wr && sel_raw) begin
                raw  <= bus.Write_data[11:0];
                mode <= MODE_RAW;
            end
            if (wr && sel_hex) begin
                hex  <= bus.Write_data[15:0];
                dp   <= bus.Write_data[19:16];
                mode <= MODE_SCAN;
                cnt  <= '0;
                idx  <= '0;
            end
            if (wr && sel_ctrl) begin
                blank <= bus.Write_data[4];
                if (bus.Write_data[3]) frame_done <= 1'b0;
            end
            // Placed after the clear so a simultaneous frame completion wins.
            if (mode == MODE_SCAN && wrap && idx == 2'd3) frame_done <= 1'b1;
            leds <= leds_nxt;
        end
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed checks of register access, scanning, blanking and reset.
module tb_seg_display_ctrl;
    localparam logic [31:0] RAW_A  = 32'h4000_0010;
    localparam logic [31:0] HEX_A  = 32'h4000_0014;
    localparam logic [31:0] CTRL_A = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] leds;
    int          checks = 0;
    int          errors = 0;

    seg_display_ctrl_if bus ();
    seg_display_ctrl #(.BASE_ADDR(32'h4000_0010), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Address    = a;
        bus.Write_data = d;
        bus.MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.Address = a;
        bus.MemRead = 1'b1;
        #1;
        d = bus.Read_data;
        bus.MemRead = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        reset = 1'b0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Address = '0;
        bus.Write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'hf80) begin errors++; $display("FAIL reset_leds got %h want f80", leds); end
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", r); end
        bus.Address = 32'h0;
        #1;
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit0 got %b want 0", bus.hit); end
    endtask

    task automatic test_raw;
        logic [31:0] r;
        bus_write(RAW_A, 32'h0000_0e06);
        @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'he06) begin errors++; $display("FAIL raw_leds got %h want e06", leds); end
        bus_read(RAW_A, r);
        checks++;
        if (r !== 32'h0000_0e06) begin errors++; $display("FAIL raw_read got %h want e06", r); end
        bus_read(CTRL_A, r);
        checks++;
        if (r[0] !== 1'b0) begin errors++; $display("FAIL raw_mode got %b want 0", r[0]); end
        // read and write in the same cycle see the old value
        @(negedge clk);
        bus.Address = RAW_A;
        bus.Write_data = 32'h0000_0123;
        bus.MemWrite = 1'b1;
        bus.MemRead = 1'b1;
        #1;
        checks++;
        if (bus.Read_data !== 32'h0000_0e06) begin errors++; $display("FAIL rw_same got %h want e06", bus.Read_data); end
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        bus.MemRead = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'h123) begin errors++; $display("FAIL rw_leds got %h want 123", leds); end
    endtask

    task automatic test_scan;
        logic [11:0] exp_d [4];
        logic [31:0] r;
        exp_d = '{12'hee6, 12'hd4f, 12'hb5b, 12'h786};
        bus_write(HEX_A, 32'h0009_1234);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (leds !== exp_d[(k - 1) / 4]) begin
                errors++;
                $display("FAIL scan_cycle%0d got %h want %h", k, leds, exp_d[(k - 1) / 4]);
            end
            if (k == 15) begin
                bus_read(CTRL_A, r);
                checks++;
                if (r !== 32'h7) begin errors++; $display("FAIL scan_ctrl_pre got %h want 7", r); end
            end
        end
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h9) begin errors++; $display("FAIL scan_frame_done got %h want 9", r); end
        bus_read(HEX_A, r);
        checks++;
        if (r !== 32'h0009_1234) begin errors++; $display("FAIL scan_hex_read got %h want 91234", r); end
    endtask

    task automatic test_frame_clear;
        logic [31:0] r;
        repeat (15) @(posedge clk);
        bus_write(CTRL_A, 32'h8);
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h9) begin errors++; $display("FAIL clear_vs_set got %h want 9", r); end
        bus_write(CTRL_A, 32'h8);
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL clear_done got %h want 1", r); end
    endtask

    task automatic test_blank;
        logic [31:0] r;
        bus_write(CTRL_A, 32'h10);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'hf00) begin errors++; $display("FAIL blank_leds got %h want f00", leds); end
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h13) begin errors++; $display("FAIL blank_ctrl got %h want 13", r); end
        bus_write(CTRL_A, 32'h0);
        @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'hd4f) begin errors++; $display("FAIL unblank_leds got %h want d4f", leds); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'hb5b) begin errors++; $display("FAIL unblank_next got %h want b5b", leds); end
    endtask

    task automatic test_unmapped;
        logic [31:0] bad [2];
        logic [31:0] r;
        bad = '{32'h4000_001c, 32'h4000_0012};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.Address = bad[i];
            bus.Write_data = 32'hffff_ffff;
            bus.MemWrite = 1'b1;
            bus.MemRead = 1'b1;
            #1;
            checks++;
            if (bus.hit !== 1'b0) begin errors++; $display("FAIL unmapped_hit%0d got %b want 0", i, bus.hit); end
            checks++;
            if (bus.Read_data !== 32'h0) begin errors++; $display("FAIL unmapped_rd%0d got %h want 0", i, bus.Read_data); end
            @(posedge clk);
            #1;
            bus.MemWrite = 1'b0;
            bus.MemRead = 1'b0;
        end
        bus_read(RAW_A, r);
        checks++;
        if (r !== 32'h123) begin errors++; $display("FAIL unmapped_raw got %h want 123", r); end
        bus_read(HEX_A, r);
        checks++;
        if (r !== 32'h0009_1234) begin errors++; $display("FAIL unmapped_hex got %h want 91234", r); end
        bus_read(CTRL_A, r);
        checks++;
        if ((r & 32'h19) !== 32'h1) begin errors++; $display("FAIL unmapped_ctrl got %h want x1 under mask 19", r); end
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (leds !== 12'hf80) begin errors++; $display("FAIL async_leds got %h want f80", leds); end
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL async_ctrl got %h want 0", r); end
        bus_read(HEX_A, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL async_hex got %h want 0", r); end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (leds !== 12'hf80) begin errors++; $display("FAIL post_reset_leds got %h want f80", leds); end
        bus_read(CTRL_A, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_scan();
        test_frame_clear();
        test_blank();
        test_unmapped();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
